uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Transmit scheduler that shares the single UART transmitter among NREQ byte requesters using round-robin arbitration.
- Drives the transmitter load handshake and owns the UART framing/baud configuration (eight, pen, ohel, baud).
- Applies configuration changes only between frames, so a frame is never sent with mixed settings.
- Sits between client logic and uart_top's transmit path.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, data byte width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
req  in  NREQ  requester i has a byte pending; level, held until granted
req_data  in  NREQ*DW  packed bytes, requester i at [DW*i+DW-1 : DW*i]
grant  out  NREQ  one-hot, one-cycle acknowledge that requester i's byte was taken
cfg_eight  in  1  requested 8-bit mode
cfg_pen  in  1  requested parity enable
cfg_ohel  in  1  requested odd/even parity select
cfg_baud  in  4  requested baud select
eight  out  1  applied 8-bit mode, to the UART
pen  out  1  applied parity enable
ohel  out  1  applied parity select
baud  out  4  applied baud select
tx_ready  in  1  transmitter idle and able to accept a byte
tx_load  out  1  one-cycle load strobe to the transmitter
tx_data  out  DW  byte presented with tx_load; held until next load
busy  out  1  high in any state other than IDLE
owner  out  clog2(NREQ)  index of the last granted requester

Behaviour:
- All outputs are registered. On the rising clk edge with reset==0:
  - state=IDLE; tx_load=0; grant=0; tx_data=0; busy=0
  - owner=NREQ-1 (rr pointer), so requester 0 wins first
  - eight=0, pen=0, ohel=0, baud=4'd11
- States: IDLE, CFG, WAIT_LO, WAIT_HI.
- IDLE, evaluated each edge, first match wins:
  1. If {cfg_*} differs from the applied {eight,pen,ohel,baud} and tx_ready==1: go to CFG.
  2. Else if tx_ready==1 and |req: pick the winner by round-robin, searching upward from owner+1 and wrapping modulo NREQ. Next cycle: tx_load=1, grant[w]=1, tx_data=req_data[w], owner=w. Go to WAIT_LO.
  3. Else stay in IDLE.
- Latency from req to load: req sampled high at edge k in IDLE (tx_ready=1, no config pending) gives tx_load and grant high for the cycle after edge k. Both are exactly 1 cycle wide.
- CFG (exactly 1 cycle): applied outputs take the cfg_* values sampled on entry; return to IDLE. A config change pending together with a request delays the grant by 2 cycles. Config always wins.
- WAIT_LO: wait for tx_ready==0 (transmitter accepted the byte), then go to WAIT_HI. No timeout.
- WAIT_HI: wait for tx_ready==1 (frame done), then go to IDLE. req is not sampled during WAIT_LO/WAIT_HI.
- Granted requester: must deassert req or present its next byte by the cycle after grant. Because of the WAIT states, a held req is not re-granted before the frame completes.
- A single requester continuously requesting is granted once per frame. Fairness: with all requesters high, grants rotate 0,1,2,...,NREQ-1,0.
- Config inputs that change while not in IDLE are ignored until the return to IDLE; the latest values then win.
- If tx_ready==0 in IDLE, nothing happens, including config application.
- Reset mid-operation: immediate return to reset values. An in-flight byte is not retried and no grant is re-issued.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, CFG, WAIT_LO, WAIT_HI)
  - BAUD_RST=4'd11
  - default DW
  - helper function clog2
- One sub-module, uart_rr_arb: combinational rotate/priority-encode of req against a pointer, producing a one-hot winner, the winner index and a valid flag.
- Pointer register and FSM stay in uart_tx_sched.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req=4'b1111 -> tx_load=0, grant=0, busy=0, baud=11, eight=pen=ohel=0; after release with tx_ready=1, first grant=4'b0001.
- Single request: req=4'b0100, req_data[23:16]=8'hA5, tx_ready=1 -> tx_load and grant=4'b0100 one cycle later, tx_data=8'hA5, owner=2; model drops tx_ready for 10 cycles -> no new load until tx_ready returns.
- Fairness: req=4'b1111 held, transmitter model busy 5 cycles per byte -> grant order 0,1,2,3,0,1; no back-to-back grant to the same requester.
- Config vs request: in IDLE, cfg_baud=4'd7, cfg_pen=1 and req=4'b0001 simultaneously -> baud=7, pen=1 applied first (CFG cycle), tx_load follows 2 cycles later than without the config change.
- Config during frame: change cfg_eight=1 while in WAIT_HI -> eight stays 0 until tx_ready=1 returns to IDLE, then eight=1 before the next tx_load.
- Reset mid-frame: assert reset=0 in WAIT_LO -> next cycle busy=0, owner=NREQ-1, applied config back to defaults, no stray grant after release with req=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CFG     = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } state_e;

  // Baud select applied out of reset
  localparam logic [3:0] BAUD_RST = 4'd11;

  // Default data byte width
  localparam int unsigned DW_DEF = 8;

  // Ceiling log2; callers guarantee n >= 2 so the result is at least 1
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin arbiter: searches upward from ptr+1, wrapping modulo NREQ.
module uart_rr_arb
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]        req,
  input  logic [clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]        win,
  output logic [clog2(NREQ)-1:0] win_idx,
  output logic                   valid
);

  localparam int unsigned IW = clog2(NREQ);

  int unsigned     pos;
  logic [NREQ-1:0] shifted;

  // Walk offsets from farthest to nearest so the nearest candidate after ptr is kept last
  always_comb begin
    win     = '0;
    win_idx = '0;
    valid   = 1'b0;
    pos     = 0;
    shifted = '0;
    for (int i = NREQ; i > 0; i--) begin
      pos = 32'(ptr) + 32'(i);
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      shifted = req >> pos;
      if (shifted[0]) begin
        win     = NREQ'(1) << pos;
        win_idx = IW'(pos);
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler sharing one UART transmitter among NREQ requesters.
// Owns the applied framing/baud configuration and only changes it between frames.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = DW_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DW-1:0]     req_data,
  output logic [NREQ-1:0]        grant,
  input  logic                   cfg_eight,
  input  logic                   cfg_pen,
  input  logic                   cfg_ohel,
  input  logic [3:0]             cfg_baud,
  output logic                   eight,
  output logic                   pen,
  output logic                   ohel,
  output logic [3:0]             baud,
  input  logic                   tx_ready,
  output logic                   tx_load,
  output logic [DW-1:0]          tx_data,
  output logic                   busy,
  output logic [clog2(NREQ)-1:0] owner
);

  localparam int unsigned IW = clog2(NREQ);

  state_e          state_q;
  state_e          state_d;
  logic [NREQ-1:0] arb_win;
  logic [IW-1:0]   arb_idx;
  logic            arb_valid;
  logic [DW-1:0]   win_data;
  logic            cfg_diff;
  logic            do_cfg;
  logic            do_grant;

  // owner doubles as the round-robin pointer
  uart_rr_arb #(
    .NREQ(NREQ)
  ) u_arb (
    .req     (req),
    .ptr     (owner),
    .win     (arb_win),
    .win_idx (arb_idx),
    .valid   (arb_valid)
  );

  // Select the winning requester's byte through the one-hot winner vector
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_win[i]) begin
        win_data = win_data | req_data[i*DW +: DW];
      end
    end
  end

  assign cfg_diff = ({cfg_eight, cfg_pen, cfg_ohel, cfg_baud} != {eight, pen, ohel, baud});

  // Config takes priority over a pending request; neither acts while the transmitter is busy
  assign do_cfg   = (state_q == IDLE) && tx_ready && cfg_diff;
  assign do_grant = (state_q == IDLE) && tx_ready && !cfg_diff && arb_valid;

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (do_cfg) begin
          state_d = CFG;
        end else if (do_grant) begin
          state_d = WAIT_LO;
        end
      end
      CFG:     state_d = IDLE;
      WAIT_LO: if (!tx_ready) state_d = WAIT_HI;
      WAIT_HI: if (tx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      tx_load <= 1'b0;
      grant   <= '0;
      tx_data <= '0;
      busy    <= 1'b0;
      owner   <= IW'(NREQ - 1);
      eight   <= 1'b0;
      pen     <= 1'b0;
      ohel    <= 1'b0;
      baud    <= BAUD_RST;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      tx_load <= do_grant;
      grant   <= do_grant ? arb_win : '0;
      if (do_grant) begin
        tx_data <= win_data;
        owner   <= arb_idx;
      end
      if (do_cfg) begin
        eight <= cfg_eight;
        pen   <= cfg_pen;
        ohel  <= cfg_ohel;
        baud  <= cfg_baud;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: directed stimulus pushes expected loads, a monitor checks them.
module tb_uart_tx_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;

  typedef struct packed {
    logic [3:0] grant;
    logic [7:0] data;
    logic [1:0] owner;
    logic [6:0] cfg;  // {eight, pen, ohel, baud}
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   grant;
  logic              cfg_eight, cfg_pen, cfg_ohel;
  logic [3:0]        cfg_baud;
  logic              eight, pen, ohel;
  logic [3:0]        baud;
  logic              tx_ready;
  logic              tx_load;
  logic [DW-1:0]     tx_data;
  logic              busy;
  logic [1:0]        owner;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   nloads   = 0;
  int   load_cyc = 0;
  int   busy_len = 5;
  logic prev_load = 1'b0;
  exp_t sb_q[$];

  uart_tx_sched #(
    .NREQ(NREQ),
    .DW  (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .cfg_eight (cfg_eight),
    .cfg_pen   (cfg_pen),
    .cfg_ohel  (cfg_ohel),
    .cfg_baud  (cfg_baud),
    .eight     (eight),
    .pen       (pen),
    .ohel      (ohel),
    .baud      (baud),
    .tx_ready  (tx_ready),
    .tx_load   (tx_load),
    .tx_data   (tx_data),
    .busy      (busy),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: after a load, tx_ready stays low for busy_len cycles
  logic tx_rdy_m = 1'b1;
  int   tx_cnt   = 0;
  always @(posedge clk) begin
    if (tx_load === 1'b1) begin
      tx_rdy_m <= 1'b0;
      tx_cnt   <= busy_len;
    end else if (tx_cnt > 1) begin
      tx_cnt <= tx_cnt - 1;
    end else if (tx_cnt == 1) begin
      tx_cnt   <= 0;
      tx_rdy_m <= 1'b1;
    end
  end
  assign tx_ready = tx_rdy_m;

  // Monitor: every load is matched against the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    exp_t act;
    if (reset === 1'b1 && (tx_load !== 1'b0 || grant !== '0)) begin
      checks++;
      if (tx_load !== 1'b1 || grant == '0) begin
        failures++;
        $display("FAIL load_grant_pair: tx_load=%b grant=%b required both active", tx_load, grant);
      end
      checks++;
      if (prev_load === 1'b1) begin
        failures++;
        $display("FAIL load_width: tx_load high %0d cycles in a row, required 1", 2);
      end
      if (tx_load === 1'b1) begin
        nloads++;
        load_cyc = cyc;
        act = {grant, tx_data, owner, eight, pen, ohel, baud};
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_load: got %h with empty scoreboard", act);
        end else begin
          e = sb_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL load_%0d: got grant=%b data=%h owner=%0d cfg=%h, required grant=%b data=%h owner=%0d cfg=%h",
                     nloads, act.grant, act.data, act.owner, act.cfg,
                     e.grant, e.data, e.owner, e.cfg);
          end
        end
      end
    end
    prev_load = tx_load;
  end

  function automatic exp_t mk(input logic [3:0] g, input logic [7:0] d,
                              input logic [1:0] o, input logic [6:0] c);
    return {g, d, o, c};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req_v);
    end
  endtask

  task automatic wait_loads(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (nloads < target && n < budget) begin
      step(1);
      n++;
    end
    checks++;
    if (nloads < target) begin
      failures++;
      $display("FAIL %s: %0d loads after %0d cycles, required %0d", name, nloads, budget, target);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step(1);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  localparam logic [6:0] CFG_DEF = {3'b000, 4'd11};
  localparam logic [6:0] CFG_B7  = {1'b0, 1'b1, 1'b0, 4'd7};
  localparam logic [6:0] CFG_E8  = {1'b1, 1'b1, 1'b0, 4'd7};

  initial begin
    int c0;
    int l0;
    int n0;

    reset     = 1'b0;
    req       = '0;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    cfg_eight = 1'b0;
    cfg_pen   = 1'b0;
    cfg_ohel  = 1'b0;
    cfg_baud  = 4'd11;

    // Reset held with all requests pending
    req = 4'b1111;
    step(3);
    check("rst_tx_load", {31'd0, tx_load}, 32'd0);
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_baud", {28'd0, baud}, 32'd11);
    check("rst_fmt", {29'd0, eight, pen, ohel}, 32'd0);
    check("rst_owner", {30'd0, owner}, 32'd3);
    sb_q.push_back(mk(4'b0001, 8'h10, 2'd0, CFG_DEF));
    reset = 1'b1;
    wait_loads(1, 20, "first_grant_timeout");
    req = '0;
    wait_idle(40, "idle_after_first");

    // Single request, then a second requester waits out a long frame
    busy_len = 10;
    req_data[23:16] = 8'hA5;
    sb_q.push_back(mk(4'b0100, 8'hA5, 2'd2, CFG_DEF));
    req = 4'b0100;
    c0 = cyc;
    wait_loads(2, 20, "single_timeout");
    check("single_latency", 32'(load_cyc - c0), 32'd1);
    l0 = load_cyc;
    sb_q.push_back(mk(4'b0010, 8'h11, 2'd1, CFG_DEF));
    req = 4'b0010;
    wait_loads(3, 40, "second_timeout");
    check("frame_gap", 32'(load_cyc - l0), 32'd13);
    req = '0;
    wait_idle(40, "idle_after_single");

    // Fairness from a fresh reset with every requester held
    reset = 1'b0;
    step(2);
    check("rst2_owner", {30'd0, owner}, 32'd3);
    reset = 1'b1;
    busy_len = 5;
    n0 = nloads;
    sb_q.push_back(mk(4'b0001, 8'h10, 2'd0, CFG_DEF));
    sb_q.push_back(mk(4'b0010, 8'h11, 2'd1, CFG_DEF));
    sb_q.push_back(mk(4'b0100, 8'hA5, 2'd2, CFG_DEF));
    sb_q.push_back(mk(4'b1000, 8'h13, 2'd3, CFG_DEF));
    sb_q.push_back(mk(4'b0001, 8'h10, 2'd0, CFG_DEF));
    sb_q.push_back(mk(4'b0010, 8'h11, 2'd1, CFG_DEF));
    req = 4'b1111;
    wait_loads(n0 + 6, 150, "fair_timeout");
    req = '0;
    wait_idle(40, "idle_after_fair");

    // Config change and request together: config applied first, load two cycles later
    cfg_baud = 4'd7;
    cfg_pen  = 1'b1;
    req      = 4'b0001;
    sb_q.push_back(mk(4'b0001, 8'h10, 2'd0, CFG_B7));
    c0 = cyc;
    step(1);
    check("cfg_baud_applied", {28'd0, baud}, 32'd7);
    check("cfg_pen_applied", {31'd0, pen}, 32'd1);
    check("cfg_busy", {31'd0, busy}, 32'd1);
    check("cfg_no_load", {31'd0, tx_load}, 32'd0);
    wait_loads(nloads + 1, 20, "cfg_req_timeout");
    check("cfg_latency", 32'(load_cyc - c0), 32'd3);
    req = '0;
    wait_idle(40, "idle_after_cfg");

    // Config change mid-frame is held until the frame completes
    busy_len = 10;
    sb_q.push_back(mk(4'b0100, 8'hA5, 2'd2, CFG_B7));
    req = 4'b0100;
    wait_loads(nloads + 1, 20, "frame_timeout");
    l0 = load_cyc;
    req = '0;
    step(2);
    check("wait_hi_busy", {31'd0, busy}, 32'd1);
    cfg_eight = 1'b1;
    req = 4'b1000;
    sb_q.push_back(mk(4'b1000, 8'h13, 2'd3, CFG_E8));
    step(3);
    check("eight_held", {31'd0, eight}, 32'd0);
    wait_loads(nloads + 1, 40, "post_frame_timeout");
    check("post_frame_gap", 32'(load_cyc - l0), 32'd15);
    req = '0;
    wait_idle(40, "idle_after_frame");

    // Reset while waiting for the transmitter to accept
    sb_q.push_back(mk(4'b0001, 8'h10, 2'd0, CFG_E8));
    req = 4'b0001;
    wait_loads(nloads + 1, 20, "midrst_timeout");
    reset = 1'b0;
    req   = '0;
    step(1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_owner", {30'd0, owner}, 32'd3);
    check("midrst_fmt", {29'd0, eight, pen, ohel}, 32'd0);
    check("midrst_baud", {28'd0, baud}, 32'd11);
    check("midrst_load", {27'd0, tx_load, grant}, 32'd0);
    reset = 1'b1;
    n0 = nloads;
    step(25);
    check("no_stray_grant", 32'(nloads), 32'(n0));
    check("cfg_reapplied", {27'd0, eight, baud}, {27'd0, 1'b1, 4'd7});
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
